// File: rtl/uart_rx_drive.sv
// uart_rx_drive: mid-bit sampling UART receiver.
// Two-flop synchronizer, baud counter, six-state FSM, parity/framing flags.

module uart_rx_drive #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int CPB  = CLK_FREQ / BAUD;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);
    localparam bit ODD  = (PARITY == 1);
    localparam bit HASP = (PARITY != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t state;
    state_t state_nx;

    logic                 rx_m;
    logic                 rx_s;
    logic [CW-1:0]        cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_err;
    logic [7:0]           data_ext;

    logic cnt_term;
    logic half_term;
    logic last_bit;
    logic start_ok;
    logic shift_en;
    logic par_en;
    logic stop_en;

    assign cnt_term  = (cnt == CW'(CPB - 1));
    assign half_term = (cnt == CW'(HALF - 1));
    assign last_bit  = (bit_idx == 4'(DATA_BITS - 1));

    // two-flop synchronizer; idles high so reset looks like a quiet line
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= uart_rx;
            rx_s <= rx_m;
        end
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (!rx_s) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (half_term) begin
                    state_nx = rx_s ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_term && last_bit) begin
                    state_nx = HASP ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (cnt_term) begin
                    state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_term) begin
                    state_nx = rx_s ? S_IDLE : S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // per-state strobes and the busy flag
    always_comb begin
        rx_busy  = 1'b1;
        start_ok = 1'b0;
        shift_en = 1'b0;
        par_en   = 1'b0;
        stop_en  = 1'b0;
        unique case (state)
            S_IDLE:   rx_busy  = 1'b0;
            S_START:  start_ok = half_term && !rx_s;
            S_DATA:   shift_en = cnt_term;
            S_PARITY: par_en   = cnt_term;
            S_STOP:   stop_en  = cnt_term;
            S_BREAK:  rx_busy  = 1'b1;
            default:  rx_busy  = 1'b1;
        endcase
    end

    // baud counter: restarts on every state change, wraps per data bit
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state_nx != state) begin
            cnt <= '0;
        end else if (cnt_term) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // bit index and LSB-first shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx <= '0;
            shreg   <= '0;
        end else if (start_ok) begin
            bit_idx <= '0;
        end else if (shift_en) begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
        end
    end

    // parity check against the completed data word
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (par_en) begin
            par_err <= ODD ? ~(^shreg ^ rx_s)
                           :  (^shreg ^ rx_s);
        end
    end

    // zero-extend narrow words into the byte output
    always_comb begin
        data_ext = '0;
        data_ext[DATA_BITS-1:0] = shreg;
    end

    // registered result pulses at the stop sample
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
        end else begin
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            if (stop_en) begin
                rx_data       <= data_ext;
                rx_valid      <= rx_s;
                rx_frame_err  <= !rx_s;
                rx_parity_err <= rx_s && HASP && par_err;
            end
        end
    end

endmodule
